hedios_serial_rx: RTL and testbench

Receive-side counterpart of the HEDIOS serial packet transmitter. It samples the asynchronous `rx_line` pin, recovers 8N1 UART bytes and reassembles them into 5-byte HEDIOS packets: one command byte, then 32 data bits least-significant byte first. It sits between the board RX pin and the HEDIOS packet consumer, and delivers each complete packet as a one-cycle strobe with held command/data registers.

---
 rtl/hedios_serial_rx_if.sv | 16 +
 rtl/hedios_serial_rx.sv | 189 ++++++++++++++++++
 tb/tb_hedios_serial_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hedios_serial_rx_if.sv
// Packet-side bundle of the HEDIOS serial receiver: held command/data, strobes and busy.
interface hedios_serial_rx_if;
    logic [7:0]  packet_command;
    logic [31:0] packet_data;
    logic        packet_valid;
    logic        frame_error;
    logic        sync_lost;
    logic        rx_busy;

    modport master (
        output packet_command, packet_data, packet_valid, frame_error, sync_lost, rx_busy
    );
    modport slave (
        input  packet_command, packet_data, packet_valid, frame_error, sync_lost, rx_busy
    );
endinterface

// File: rtl/hedios_serial_rx.sv
// HEDIOS serial receiver: 8N1 byte recovery plus 5-byte packet assembly (cmd, data LSB first).
// Define HEDIOS_RX_TIMEOUT_EN to build the inter-byte silence timeout that drops partial packets.
module hedios_serial_rx #(
    parameter int CLK_RATE     = 100_000_000,
    parameter int BAUD_RATE    = 1_000_000,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_line,
    hedios_serial_rx_if.master    pkt
);
    // CLKS_PER_BIT must be at least 8 for the mid-bit sampling to be meaningful.
    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic          sync1_q, rxs_q, rxs_prev_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    cmd_sh_q, cmd_sh_d;
    logic [23:0]   data_sh_q, data_sh_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          start_edge, byte_ok;

`ifdef HEDIOS_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          slost_q, slost_d;
`endif

    assign start_edge = (state_q == IDLE) && rxs_prev_q && !rxs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            cmd_sh_q   <= '0;
            data_sh_q  <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef HEDIOS_RX_TIMEOUT_EN
            to_cnt_q   <= '0;
            slost_q    <= 1'b0;
`endif
        end else begin
            sync1_q    <= rx_line;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            cmd_sh_q   <= cmd_sh_d;
            data_sh_q  <= data_sh_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef HEDIOS_RX_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            slost_q    <= slost_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        cmd_sh_d   = cmd_sh_q;
        data_sh_d  = data_sh_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        byte_ok    = 1'b0;
`ifdef HEDIOS_RX_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        slost_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is still seen.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxs_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        ferr_d     = 1'b1;
                        byte_cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (byte_ok) begin
            case (byte_cnt_q)
                3'd0:    cmd_sh_d         = shreg_q;
                3'd1:    data_sh_d[7:0]   = shreg_q;
                3'd2:    data_sh_d[15:8]  = shreg_q;
                3'd3:    data_sh_d[23:16] = shreg_q;
                default: begin
                    cmd_d   = cmd_sh_q;
                    data_d  = {shreg_q, data_sh_q};
                    valid_d = 1'b1;
                end
            endcase
            byte_cnt_d = (byte_cnt_q == 3'd4) ? 3'd0 : byte_cnt_q + 3'd1;
        end

`ifdef HEDIOS_RX_TIMEOUT_EN
        // Only counts silence between bytes of a partial packet; a start edge always wins.
        if (start_edge || state_q != IDLE || byte_cnt_q == 3'd0) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d   = '0;
            byte_cnt_d = '0;
            slost_d    = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
    end

    assign pkt.packet_command = cmd_q;
    assign pkt.packet_data    = data_q;
    assign pkt.packet_valid   = valid_q;
    assign pkt.frame_error    = ferr_q;
    assign pkt.rx_busy        = (state_q != IDLE) || (byte_cnt_q != 3'd0);
`ifdef HEDIOS_RX_TIMEOUT_EN
    assign pkt.sync_lost      = slost_q;
`else
    assign pkt.sync_lost      = 1'b0;
`endif

endmodule

// File: tb/tb_hedios_serial_rx.sv
// Scoreboard bench for hedios_serial_rx: directed packets, framing, glitch, timeout, reset.
module tb_hedios_serial_rx;
    localparam int CPB = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;

    hedios_serial_rx_if pkt_if();

    hedios_serial_rx #(
        .CLK_RATE(100_000_000), .BAUD_RATE(1_000_000), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .rst(rst), .rx_line(rx_line), .pkt(pkt_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int n_chk = 0;
    int n_pass = 0;
    int ferr_cnt = 0;
    int slost_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Monitor: pops the scoreboard on every packet strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_if.frame_error) ferr_cnt++;
            if (pkt_if.sync_lost)   slost_cnt++;
            if (pkt_if.packet_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("pkt_cmd",  {56'd0, pkt_if.packet_command}, {56'd0, e.cmd});
                    check("pkt_data", {32'd0, pkt_if.packet_data},    {32'd0, e.data});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx_line = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx_line = stop_ok;
        repeat (CPB) @(posedge clk);
        rx_line = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] data, input logic expect_it);
        exp_t e;
        e.cmd = cmd;
        e.data = data;
        if (expect_it) expq.push_back(e);
        send_byte(cmd, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
    endtask

    task automatic idle_bits(input int n);
        rx_line = 1'b1;
        repeat (n * CPB) @(posedge clk);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 3000 && expq.size() != 0; i++) @(posedge clk);
        check(nm, 64'(expq.size()), 64'd0);
    endtask

    initial begin
        int exp_slost;
        exp_t e;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_cmd",  {56'd0, pkt_if.packet_command}, 64'd0);
        check("rst_data", {32'd0, pkt_if.packet_data},    64'd0);
        check("rst_busy", {63'd0, pkt_if.rx_busy},        64'd0);
        check("rst_strobes", {61'd0, pkt_if.packet_valid, pkt_if.frame_error, pkt_if.sync_lost}, 64'd0);
        rst = 1'b0;
        idle_bits(2);

        // Single packet.
        send_pkt(8'hA5, 32'h1234_5678, 1'b1);
        idle_bits(2);
        drain("drain_single");

        // Back-to-back, zero idle between frames.
        send_pkt(8'h01, 32'hDEAD_BEEF, 1'b1);
        send_pkt(8'h02, 32'h8000_0000, 1'b1);
        idle_bits(2);
        drain("drain_b2b");
        check("ferr_none_yet", 64'(ferr_cnt), 64'd0);

        // Framing error on third byte, then clean packet.
        send_byte(8'h09, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        idle_bits(1);
        check("ferr_once", 64'(ferr_cnt), 64'd1);
        check("busy_after_ferr", {63'd0, pkt_if.rx_busy}, 64'd0);
        send_pkt(8'h07, 32'h0102_0304, 1'b1);
        idle_bits(2);
        drain("drain_frame");

        // 30-cycle glitch: rejected at mid-start resample.
        rx_line = 1'b0;
        repeat (30) @(posedge clk);
        rx_line = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("glitch_busy", {63'd0, pkt_if.rx_busy}, 64'd0);
        check("glitch_cmd",  {56'd0, pkt_if.packet_command}, 64'h07);
        check("glitch_data", {32'd0, pkt_if.packet_data},    64'h0102_0304);
        check("glitch_ferr", 64'(ferr_cnt), 64'd1);

        // Timeout: bytes 11,22, 25 bit periods idle, then 33,44,55,66,77.
`ifdef HEDIOS_RX_TIMEOUT_EN
        e.cmd = 8'h33; e.data = 32'h7766_5544; exp_slost = 1;
`else
        // No timeout: 11,22,33,44,55 form one packet; 66,77 stay partial.
        e.cmd = 8'h11; e.data = 32'h5544_3322; exp_slost = 0;
`endif
        expq.push_back(e);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle_bits(25);
        @(negedge clk);
        check("timeout_busy", {63'd0, pkt_if.rx_busy}, 64'(1 - exp_slost));
        check("timeout_slost", 64'(slost_cnt), 64'(exp_slost));
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        idle_bits(2);
        drain("drain_timeout");

        // Reset during bit 4 of byte 2.
        send_byte(8'h5A, 1'b1);
        send_byte(8'h11, 1'b1);
        rx_line = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_line = 1'b1;
            repeat (CPB) @(posedge clk);
        end
        rx_line = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        rst = 1'b1;
        rx_line = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_rst_cmd",  {56'd0, pkt_if.packet_command}, 64'd0);
        check("mid_rst_data", {32'd0, pkt_if.packet_data},    64'd0);
        check("mid_rst_busy", {63'd0, pkt_if.rx_busy},        64'd0);
        rst = 1'b0;
        idle_bits(2);
        send_pkt(8'hC3, 32'hCAFE_F00D, 1'b1);
        idle_bits(2);
        drain("drain_post_rst");
        @(negedge clk);
        check("hold_cmd",  {56'd0, pkt_if.packet_command}, 64'hC3);
        check("hold_data", {32'd0, pkt_if.packet_data},    64'hCAFE_F00D);
        check("ferr_total", 64'(ferr_cnt), 64'd1);
        check("slost_total", 64'(slost_cnt), 64'(exp_slost));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
